fetch_unit: RTL and testbench

//   Instruction fetch stage directly upstream of control_unit. Holds the PC,

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bundle for fetch_unit
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 24
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/fetch FSM feeding decode, with zero-flag branch resolution
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    output logic [2:0]         opcode_o,
    output logic [1:0]         funct_o,
    output logic [ADDR_W-1:0]  pc_o,
    input  logic               stall_i,
    input  logic [1:0]         branch_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               flag_we_i,
    input  logic               zero_in_i,
    output logic               zero_flag_o,
    output logic               branch_taken_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] BR_JEQ = 2'b00;
    localparam logic [1:0] BR_JNE = 2'b01;
    localparam logic [1:0] BR_JMP = 2'b10;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 zero_flag_q, zero_flag_d;
    logic                 cond_met;
    logic                 branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            zero_flag_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            zero_flag_q   <= zero_flag_d;
        end
    end

    // Branch condition looks at the registered flag, so a same-cycle flag write is not seen.
    always_comb begin
        cond_met = 1'b0;
        case (branch_i)
            BR_JEQ:  cond_met = zero_flag_q;
            BR_JNE:  cond_met = ~zero_flag_q;
            BR_JMP:  cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
        branch_taken = (state_q == S_HOLD) && !stall_i && cond_met;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        zero_flag_d   = flag_we_i ? zero_in_i : zero_flag_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem.imem_valid) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                    if (branch_taken) begin
                        pc_d = branch_target_i;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem.imem_req  = (state_q == S_REQ);
    assign imem.imem_addr = pc_q;
    assign instr_o        = instr_q;
    assign instr_valid_o  = instr_valid_q;
    assign opcode_o       = instr_q[INSTR_W-1 -: 3];
    assign funct_o        = instr_q[INSTR_W-4 -: 2];
    assign pc_o           = pc_q;
    assign zero_flag_o    = zero_flag_q;
    assign branch_taken_o = branch_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a wait-state memory model
module tb_fetch_unit;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 24;

    logic               clk;
    logic               rst;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [2:0]         opcode;
    logic [1:0]         funct;
    logic [ADDR_W-1:0]  pc;
    logic               stall;
    logic [1:0]         branch;
    logic [ADDR_W-1:0]  branch_target;
    logic               flag_we;
    logic               zero_in;
    logic               zero_flag;
    logic               branch_taken;

    int checks = 0;
    int errors = 0;

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem_if ();

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (imem_if.master),
        .instr_o         (instr),
        .instr_valid_o   (instr_valid),
        .opcode_o        (opcode),
        .funct_o         (funct),
        .pc_o            (pc),
        .stall_i         (stall),
        .branch_i        (branch),
        .branch_target_i (branch_target),
        .flag_we_i       (flag_we),
        .zero_in_i       (zero_in),
        .zero_flag_o     (zero_flag),
        .branch_taken_o  (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content: words 0 and 1 are zero, elsewhere an address-derived pattern.
    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a < 16'd2) return '0;
        return {a[7:0] ^ 8'hC3, a};
    endfunction

    int   mem_wait = 0;
    logic force_valid = 1'b0;
    int   wcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (imem_if.imem_req && !imem_if.imem_valid) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    assign imem_if.imem_valid = force_valid | (imem_if.imem_req && (wcnt >= mem_wait));
    assign imem_if.imem_rdata = mem_word(imem_if.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model, evaluated on the falling edge.
    localparam logic [1:0] M_IDLE = 2'd0, M_REQ = 2'd1, M_HOLD = 2'd2;
    logic [1:0]         ref_state;
    logic [ADDR_W-1:0]  ref_pc;
    logic               ref_valid;
    logic               ref_z;
    logic               prev_valid;
    logic               exp_taken;
    logic [INSTR_W-1:0] sb[$];

    always_comb begin
        exp_taken = 1'b0;
        if (ref_state == M_HOLD && !stall)
            exp_taken = (branch == 2'b10) || (branch == 2'b00 && ref_z) || (branch == 2'b01 && !ref_z);
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_pc", pc, 16'h0000);
            check("rst_valid", instr_valid, 1'b0);
            check("rst_req", imem_if.imem_req, 1'b0);
            check("rst_zflag", zero_flag, 1'b0);
            ref_state  <= M_IDLE;
            ref_pc     <= 16'h0000;
            ref_valid  <= 1'b0;
            ref_z      <= 1'b0;
            prev_valid <= 1'b0;
            sb.delete();
        end else begin
            check("req", imem_if.imem_req, ref_state == M_REQ);
            if (ref_state == M_REQ) check("addr", imem_if.imem_addr, ref_pc);
            check("pc", pc, ref_pc);
            check("valid", instr_valid, ref_valid);
            check("zflag", zero_flag, ref_z);
            check("taken", branch_taken, exp_taken);
            if (instr_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 1'b1, 1'b0);
                end else begin
                    check("instr", instr, sb[0]);
                    check("opcode", opcode, sb[0][23:21]);
                    check("funct", funct, sb[0][20:19]);
                    sb.pop_front();
                end
            end
            prev_valid <= instr_valid;
            if (flag_we) ref_z <= zero_in;
            case (ref_state)
                M_IDLE: ref_state <= M_REQ;
                M_REQ: if (imem_if.imem_valid) begin
                    sb.push_back(mem_word(ref_pc));
                    ref_pc    <= ref_pc + 16'd1;
                    ref_valid <= 1'b1;
                    ref_state <= M_HOLD;
                end
                M_HOLD: if (!stall) begin
                    ref_valid <= 1'b0;
                    ref_state <= M_REQ;
                    if (exp_taken) ref_pc <= branch_target;
                end
                default: ref_state <= M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hold();
        for (int i = 0; i < 50 && !instr_valid; i++) tick();
        if (!instr_valid) check("timeout_hold", 1'b0, 1'b1);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && !imem_if.imem_req; i++) tick();
        if (!imem_if.imem_req) check("timeout_req", 1'b0, 1'b1);
    endtask

    task automatic take_branch(input logic [1:0] br, input logic [ADDR_W-1:0] tgt,
                               input logic exp, input string tag);
        wait_hold();
        branch        = br;
        branch_target = tgt;
        #1;
        check(tag, branch_taken, exp);
        tick();
        branch = 2'b11;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 2'b11; branch_target = '0;
        flag_we = 1'b0; zero_in = 1'b0;
        tick(); tick();
        check("reset_pc", pc, 16'h0000);
        rst = 1'b0;
        tick();
        check("req_after_release", imem_if.imem_req, 1'b1);

        // Two zero-wait fetches from 0 and 1
        wait_hold(); tick();
        wait_hold(); tick();
        check("pc_after_two", pc, 16'd2);

        take_branch(2'b10, 16'h0040, 1'b1, "jmp_taken");
        check("jmp_addr", imem_if.imem_addr, 16'h0040);

        flag_we = 1'b1; zero_in = 1'b1; tick(); flag_we = 1'b0;
        take_branch(2'b00, 16'h0080, 1'b1, "jeq_z1");
        take_branch(2'b01, 16'h0099, 1'b0, "jne_z1");
        flag_we = 1'b1; zero_in = 1'b0; tick(); flag_we = 1'b0;
        take_branch(2'b00, 16'h0090, 1'b0, "jeq_z0");
        take_branch(2'b01, 16'h0020, 1'b1, "jne_z0");
        take_branch(2'b11, 16'h0055, 1'b0, "none");

        // Flag write in the same cycle as a branch: old flag (0) decides JNE
        wait_hold();
        flag_we = 1'b1; zero_in = 1'b1;
        branch = 2'b01; branch_target = 16'h0030;
        #1;
        check("same_cycle_old_flag", branch_taken, 1'b1);
        tick();
        flag_we = 1'b0; branch = 2'b11;

        // Stall in HOLD with a pending JMP
        wait_hold();
        stall = 1'b1; branch = 2'b10; branch_target = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_no_taken", branch_taken, 1'b0);
            tick();
        end
        stall = 1'b0;
        #1;
        check("stall_release_taken", branch_taken, 1'b1);
        tick();
        branch = 2'b11;
        check("stall_target", imem_if.imem_addr, 16'h0100);

        // Wait-state memory plus spurious valid outside REQ
        mem_wait = 2;
        wait_hold(); tick();
        wait_hold();
        force_valid = 1'b1; stall = 1'b1; tick(); tick();
        force_valid = 1'b0; stall = 1'b0; tick();
        wait_hold(); tick();
        mem_wait = 0;

        // PC wrap
        take_branch(2'b10, 16'hFFFF, 1'b1, "jmp_ffff");
        wait_hold();
        check("pc_wrap", pc, 16'h0000);
        tick();
        check("wrap_addr", imem_if.imem_addr, 16'h0000);

        // Async reset during REQ with imem_valid high
        wait_hold(); tick();
        wait_req();
        check("valid_in_req", imem_if.imem_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("async_valid", instr_valid, 1'b0);
        check("async_pc", pc, 16'h0000);
        check("async_req", imem_if.imem_req, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        wait_hold(); tick();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
